// File: rtl/traffic_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_monitor_if
// Bundles the lamp lines watched by the monitor and the status/display lines
// it produces.
//   master : lamp source side (drives green/yellow/red, observes results)
//   slave  : monitor side (samples lamps, drives phase/dur/flags/HEX)
// Signals:
//   green, yellow, red : lamp lines (LEDG[0], LEDR[17], LEDR[0])
//   phase              : tracked phase, 0=UNK 1=GREEN 2=YELLOW 3=RED
//   dur, dur_valid     : last completed phase duration in ticks, update pulse
//   err_seq/time/lamp  : sticky violation flags
//   HEX1, HEX0         : active-low 7-segment tens/ones digits of dur
// -----------------------------------------------------------------------------
interface traffic_monitor_if;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned DUR_W   = 6;
    localparam int unsigned HEX_W   = 8;

    logic               green;
    logic               yellow;
    logic               red;
    logic [PHASE_W-1:0] phase;
    logic [DUR_W-1:0]   dur;
    logic               dur_valid;
    logic               err_seq;
    logic               err_time;
    logic               err_lamp;
    logic [HEX_W-1:0]   HEX1;
    logic [HEX_W-1:0]   HEX0;

    modport master (
        output green, yellow, red,
        input  phase, dur, dur_valid, err_seq, err_time, err_lamp, HEX1, HEX0
    );

    modport slave (
        input  green, yellow, red,
        output phase, dur, dur_valid, err_seq, err_time, err_lamp, HEX1, HEX0
    );
endinterface

// File: rtl/traffic_monitor.sv
// -----------------------------------------------------------------------------
// traffic_monitor
// Passive checker for the traffic-light controller lamps. Synchronizes the
// lamps, tracks the GREEN->YELLOW->RED->GREEN sequence, times each phase in
// 1 s ticks and flags sequence, timing and lamp-encoding violations.
// Ports:
//   CLOCK_50 : sole clock (posedge)
//   reset    : synchronous, active-high
//   mon      : traffic_monitor_if.slave (lamps in; phase, dur, dur_valid,
//              err_seq, err_time, err_lamp, HEX1, HEX0 out)
// Build option:
//   TRAFFIC_MONITOR_HEX_EN : when defined, builds the BCD split, segment
//   encoder and HEX registers; otherwise HEX1/HEX0 are tied to 8'hFF.
// -----------------------------------------------------------------------------
module traffic_monitor #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned GREEN_S  = 17,
    parameter int unsigned YELLOW_S = 6,
    parameter int unsigned RED_S    = 10
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    traffic_monitor_if.slave   mon
);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned SYNC_W = 2;
    localparam logic [SEC_W-1:0]  SEC_MAX  = '1;
    localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        PH_UNK    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_e;

    // Synchronizer chains; bit [SYNC_W-1] is the synchronized lamp.
    logic [SYNC_W-1:0] g_sync_q, y_sync_q, r_sync_q;
    // Fills with ones after reset; the lamp check waits until the
    // synchronizers hold real samples instead of their cleared state.
    logic [SYNC_W-1:0] prime_q;
    logic              bad_q;
    phase_e            phase_q;
    // Current phase was entered through a change, so its length is complete.
    logic              full_q;
    logic [TICK_W-1:0] tcnt_q;
    logic [SEC_W-1:0]  sec_q;
    logic [SEC_W-1:0]  dur_q;
    logic              dur_valid_q;
    logic              err_seq_q;
    logic              err_time_q;
    logic              err_lamp_q;

    phase_e            lamp_c;
    logic              lamp_ok_c;
    logic              lamp_bad_c;
    logic              tick_c;
    logic [SEC_W-1:0]  sec_inc_c;
    logic [SEC_W:0]    sec_inc_p1_c;
    logic [SEC_W-1:0]  exp_c;
    logic              legal_c;
    logic              change_c;
    logic              time_bad_c;

    // Lamp decode: one-hot lamps give a phase, anything else is "bad".
    always_comb begin
        lamp_c     = PH_UNK;
        lamp_bad_c = 1'b0;
        case ({g_sync_q[SYNC_W-1], y_sync_q[SYNC_W-1], r_sync_q[SYNC_W-1]})
            3'b100:  lamp_c = PH_GREEN;
            3'b010:  lamp_c = PH_YELLOW;
            3'b001:  lamp_c = PH_RED;
            default: lamp_bad_c = prime_q[SYNC_W-1];
        endcase
        lamp_ok_c = (lamp_c != PH_UNK);
    end

    // Timing and sequence decisions for the current cycle.
    always_comb begin
        tick_c       = (tcnt_q == TICK_TOP);
        sec_inc_c    = (tick_c && (sec_q != SEC_MAX)) ? sec_q + SEC_W'(1) : sec_q;
        sec_inc_p1_c = {1'b0, sec_inc_c} + (SEC_W+1)'(1);
        exp_c        = '0;
        legal_c      = 1'b0;
        case (phase_q)
            PH_GREEN: begin
                exp_c   = SEC_W'(GREEN_S);
                legal_c = (lamp_c == PH_YELLOW);
            end
            PH_YELLOW: begin
                exp_c   = SEC_W'(YELLOW_S);
                legal_c = (lamp_c == PH_RED);
            end
            PH_RED: begin
                exp_c   = SEC_W'(RED_S);
                legal_c = (lamp_c == PH_GREEN);
            end
            default: begin
                exp_c   = '0;
                legal_c = 1'b0;
            end
        endcase
        change_c   = (phase_q != PH_UNK) && lamp_ok_c && (lamp_c != phase_q);
        // Window is [EXP-1, EXP]; the low side is tested as dur+1 < EXP.
        time_bad_c = (sec_inc_c > exp_c) || (sec_inc_p1_c < {1'b0, exp_c});
    end

    // Synchronizers, phase tracker, counters and sticky flags.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            g_sync_q    <= '0;
            y_sync_q    <= '0;
            r_sync_q    <= '0;
            prime_q     <= '0;
            bad_q       <= 1'b0;
            phase_q     <= PH_UNK;
            full_q      <= 1'b0;
            tcnt_q      <= '0;
            sec_q       <= '0;
            dur_q       <= '0;
            dur_valid_q <= 1'b0;
            err_seq_q   <= 1'b0;
            err_time_q  <= 1'b0;
            err_lamp_q  <= 1'b0;
        end else begin
            g_sync_q    <= {g_sync_q[SYNC_W-2:0], mon.green};
            y_sync_q    <= {y_sync_q[SYNC_W-2:0], mon.yellow};
            r_sync_q    <= {r_sync_q[SYNC_W-2:0], mon.red};
            prime_q     <= {prime_q[SYNC_W-2:0], 1'b1};
            bad_q       <= lamp_bad_c;
            dur_valid_q <= 1'b0;
            tcnt_q      <= tick_c ? '0 : tcnt_q + TICK_W'(1);
            sec_q       <= sec_inc_c;

            if (lamp_bad_c && bad_q) begin
                // Persistent bad encoding: drop tracking until lamps recover.
                err_lamp_q <= 1'b1;
                phase_q    <= PH_UNK;
                full_q     <= 1'b0;
                tcnt_q     <= '0;
                sec_q      <= '0;
            end else if (phase_q == PH_UNK) begin
                if (lamp_ok_c) begin
                    phase_q <= lamp_c;
                    full_q  <= 1'b0;
                    tcnt_q  <= '0;
                    sec_q   <= '0;
                end
            end else if (change_c) begin
                phase_q <= lamp_c;
                full_q  <= 1'b1;
                tcnt_q  <= '0;
                sec_q   <= '0;
                if (legal_c) begin
                    if (full_q) begin
                        dur_q       <= sec_inc_c;
                        dur_valid_q <= 1'b1;
                        if (time_bad_c) begin
                            err_time_q <= 1'b1;
                        end
                    end
                end else begin
                    err_seq_q <= 1'b1;
                end
            end
        end
    end

    assign mon.phase     = phase_q;
    assign mon.dur       = dur_q;
    assign mon.dur_valid = dur_valid_q;
    assign mon.err_seq   = err_seq_q;
    assign mon.err_time  = err_time_q;
    assign mon.err_lamp  = err_lamp_q;

`ifdef TRAFFIC_MONITOR_HEX_EN
    localparam int unsigned DIG_W = 4;
    localparam int unsigned HEX_W = 8;

    logic [HEX_W-1:0] hex1_q;
    logic [HEX_W-1:0] hex0_q;
    logic [DIG_W-1:0] tens_c;
    logic [DIG_W-1:0] ones_c;

    // Active-low segment pattern for one decimal digit.
    function automatic logic [HEX_W-1:0] seg7(input logic [DIG_W-1:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // BCD split of the 0..63 duration.
    always_comb begin
        tens_c = DIG_W'(dur_q / SEC_W'(10));
        ones_c = DIG_W'(dur_q % SEC_W'(10));
    end

    // Display registers, one cycle behind dur.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hex1_q <= 8'hC0;
            hex0_q <= 8'hC0;
        end else begin
            hex1_q <= seg7(tens_c);
            hex0_q <= seg7(ones_c);
        end
    end

    assign mon.HEX1 = hex1_q;
    assign mon.HEX0 = hex0_q;
`else
    assign mon.HEX1 = 8'hFF;
    assign mon.HEX0 = 8'hFF;
`endif

endmodule
